// File: rtl/uart_tx_buffered_if.sv
// Write-side bus of the buffered UART transmitter.
// The byte source (master) drives wr_en/wr_data. The transmitter (slave)
// reports the FIFO state back on the other signals.
//   wr_en    : push wr_data into the FIFO on this clock edge
//   wr_data  : payload to queue
//   full     : FIFO holds FIFO_DEPTH entries
//   empty    : FIFO holds no entries
//   count    : current FIFO occupancy
//   overflow : one-cycle pulse, a write was attempted while full and was dropped
interface uart_tx_buffered_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                          wr_en;
    logic [DATA_BITS-1:0]          wr_data;
    logic                          full;
    logic                          empty;
    logic [$clog2(FIFO_DEPTH):0]   count;
    logic                          overflow;

    modport master (
        output wr_en, wr_data,
        input  full, empty, count, overflow
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, count, overflow
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// UART transmitter fronted by a FIFO, with a configurable frame format.
// Queued bytes are sent back-to-back with no idle time between frames.
// Frame: start(0), DATA_BITS payload bits LSB first, optional parity bit,
// and STOP_BITS stop bits(1). Each bit lasts CLKS_PER_BIT clocks.
// Ports:
//   clk         : system clock
//   rst         : synchronous, active-high reset (aborts the frame, flushes the FIFO)
//   wr_if       : write bus (slave side), see uart_tx_buffered_if
//   tx_data_out : serial line, idle high
//   tx_active   : high while a frame is on the line
//   tx_done     : one-cycle pulse after the last stop-bit cycle of each frame
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_buffered_if.slave  wr_if,
    output logic               tx_data_out,
    output logic               tx_active,
    output logic               tx_done
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BCW = $clog2(CLKS_PER_BIT);

    localparam logic [BCW-1:0] BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic           ODD_C     = (PARITY == 1) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q;
    logic [BCW-1:0]       baud_q;
    logic [3:0]           bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 line_q;
    logic                 active_q;
    logic                 done_q;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_d;
    logic                 full_q;
    logic                 empty_q;
    logic                 ovf_q;

    logic                 baud_end_s;
    logic                 frame_end_s;
    logic                 push_s;
    logic                 pop_s;
    logic [DATA_BITS-1:0] head_s;
    logic                 head_par_s;

    // Pop/push decisions and next occupancy; full is the registered flag,
    // so a write while full is dropped even if a pop happens on the same edge.
    always_comb begin
        baud_end_s  = (baud_q == BAUD_LAST);
        frame_end_s = (state_q == S_STOP) && baud_end_s && (bit_q == STOP_LAST);
        push_s      = wr_if.wr_en && !full_q;
        pop_s       = !empty_q && ((state_q == S_IDLE) || frame_end_s);
        head_s      = mem_q[rd_ptr_q];
        head_par_s  = (^head_s) ^ ODD_C;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; the data array needs no reset because count guards reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_if.wr_data;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    // FIFO pointers, occupancy, and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            empty_q <= (count_d == '0);
            ovf_q   <= wr_if.wr_en && full_q;
        end
    end

    // Transmit FSM with registered line, active and done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 4'd0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            line_q   <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    baud_q <= '0;
                    bit_q  <= 4'd0;
                    if (pop_s) begin
                        shift_q  <= head_s;
                        par_q    <= head_par_s;
                        state_q  <= S_START;
                        line_q   <= 1'b0;
                        active_q <= 1'b1;
                    end else begin
                        line_q   <= 1'b1;
                        active_q <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_end_s) begin
                        baud_q  <= '0;
                        bit_q   <= 4'd0;
                        line_q  <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_end_s) begin
                        baud_q <= '0;
                        if (bit_q == DATA_LAST) begin
                            bit_q <= 4'd0;
                            if (PARITY != 0) begin
                                state_q <= S_PARITY;
                                line_q  <= par_q;
                            end else begin
                                state_q <= S_STOP;
                                line_q  <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            line_q  <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (baud_end_s) begin
                        baud_q  <= '0;
                        bit_q   <= 4'd0;
                        state_q <= S_STOP;
                        line_q  <= 1'b1;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_end_s) begin
                        baud_q <= '0;
                        if (bit_q == STOP_LAST) begin
                            bit_q  <= 4'd0;
                            done_q <= 1'b1;
                            // Back-to-back: next start bit follows the last stop cycle directly.
                            if (pop_s) begin
                                shift_q <= head_s;
                                par_q   <= head_par_s;
                                state_q <= S_START;
                                line_q  <= 1'b0;
                            end else begin
                                state_q  <= S_IDLE;
                                line_q   <= 1'b1;
                                active_q <= 1'b0;
                            end
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    baud_q   <= '0;
                    bit_q    <= 4'd0;
                    line_q   <= 1'b1;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data_out    = line_q;
    assign tx_active      = active_q;
    assign tx_done        = done_q;
    assign wr_if.full     = full_q;
    assign wr_if.empty    = empty_q;
    assign wr_if.count    = count_q;
    assign wr_if.overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed testbench for uart_tx_buffered.
// dut_a: CLKS_PER_BIT=4, 8N1, depth 4 (basic, burst, overflow, wrap, reset).
// dut_b: even parity, 2 stop bits.  dut_c: odd parity, 2 stop bits.
module tb_uart_tx_buffered;
    logic clk;
    logic rst;
    logic txd_a, act_a, done_a;
    logic txd_b, act_b, done_b;
    logic txd_c, act_c, done_c;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic       rx_en = 1'b0;
    logic [7:0] rx_q[$];
    int         rx_err = 0;

    uart_tx_buffered_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_a ();
    uart_tx_buffered_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_b ();
    uart_tx_buffered_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_c ();

    uart_tx_buffered #(.CLKS_PER_BIT(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .wr_if(if_a.slave),
        .tx_data_out(txd_a), .tx_active(act_a), .tx_done(done_a));
    uart_tx_buffered #(.CLKS_PER_BIT(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .wr_if(if_b.slave),
        .tx_data_out(txd_b), .tx_active(act_b), .tx_done(done_b));
    uart_tx_buffered #(.CLKS_PER_BIT(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst(rst), .wr_if(if_c.slave),
        .tx_data_out(txd_c), .tx_active(act_c), .tx_done(done_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serial receiver on dut_a: samples mid-bit, 8N1 at 4 clocks per bit.
    initial begin
        logic [7:0] rb;
        rb = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (rx_en && txd_a === 1'b0) begin
                repeat (2) @(posedge clk);
                #2;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(posedge clk);
                    #2;
                    rb[i] = txd_a;
                end
                repeat (4) @(posedge clk);
                #2;
                if (txd_a === 1'b1) rx_q.push_back(rb);
                else rx_err++;
            end
        end
    end

    task automatic test_reset();
        logic [8:0] exp_v;
        exp_v = 9'b1_0_0_0_000_1_0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vec_cnt++;
        if ({txd_a, act_a, done_a, if_a.overflow, if_a.count, if_a.empty, if_a.full} !== exp_v) begin
            miss_cnt++;
            $display("FAIL reset_a: got %b want %b", {txd_a, act_a, done_a, if_a.overflow, if_a.count, if_a.empty, if_a.full}, exp_v);
        end
        vec_cnt++;
        if ({txd_b, act_b, done_b, if_b.overflow, if_b.count, if_b.empty, if_b.full} !== exp_v) begin
            miss_cnt++;
            $display("FAIL reset_b: got %b want %b", {txd_b, act_b, done_b, if_b.overflow, if_b.count, if_b.empty, if_b.full}, exp_v);
        end
        vec_cnt++;
        if ({txd_c, act_c, done_c, if_c.overflow, if_c.count, if_c.empty, if_c.full} !== exp_v) begin
            miss_cnt++;
            $display("FAIL reset_c: got %b want %b", {txd_c, act_c, done_c, if_c.overflow, if_c.count, if_c.empty, if_c.full}, exp_v);
        end
    endtask

    task automatic test_basic_frame();
        logic [9:0] exp_f;
        exp_f = 10'b1101001010;  // A5 framed, bit 0 = start bit
        if_a.wr_data = 8'hA5;
        if_a.wr_en   = 1'b1;
        tick();
        if_a.wr_en = 1'b0;
        vec_cnt++;
        if (if_a.count !== 3'd1 || txd_a !== 1'b1) begin
            miss_cnt++;
            $display("FAIL basic_queued: count=%0d txd=%b want count=1 txd=1", if_a.count, txd_a);
        end
        tick();
        vec_cnt++;
        if (txd_a !== 1'b0 || act_a !== 1'b1 || if_a.empty !== 1'b1) begin
            miss_cnt++;
            $display("FAIL basic_start: txd=%b act=%b empty=%b want 0 1 1", txd_a, act_a, if_a.empty);
        end
        for (int t = 0; t < 40; t++) begin
            vec_cnt++;
            if (txd_a !== exp_f[t/4] || done_a !== 1'b0) begin
                miss_cnt++;
                $display("FAIL basic_bit t=%0d: txd=%b done=%b want txd=%b done=0", t, txd_a, done_a, exp_f[t/4]);
            end
            tick();
        end
        vec_cnt++;
        if (done_a !== 1'b1 || act_a !== 1'b0 || txd_a !== 1'b1) begin
            miss_cnt++;
            $display("FAIL basic_done: done=%b act=%b txd=%b want 1 0 1", done_a, act_a, txd_a);
        end
        tick();
        vec_cnt++;
        if (done_a !== 1'b0) begin
            miss_cnt++;
            $display("FAIL basic_done_pulse: done=%b want 0", done_a);
        end
    endtask

    task automatic test_burst();
        logic [29:0] exp_f;
        logic [3:0]  got_v;
        logic [3:0]  exp_v;
        int          peak;
        exp_f = {10'b1000000110, 10'b1000000100, 10'b1000000010};
        if_a.wr_data = 8'h01;
        if_a.wr_en   = 1'b1;
        tick();
        peak = int'(if_a.count);
        if_a.wr_data = 8'h02;
        tick();
        for (int t = 0; t <= 120; t++) begin
            if (int'(if_a.count) > peak) peak = int'(if_a.count);
            got_v = {txd_a, done_a, if_a.empty, act_a};
            exp_v = {(t < 120) ? exp_f[t/4] : 1'b1,
                     (t == 40 || t == 80 || t == 120) ? 1'b1 : 1'b0,
                     (t >= 80) ? 1'b1 : 1'b0,
                     (t < 120) ? 1'b1 : 1'b0};
            vec_cnt++;
            if (got_v !== exp_v) begin
                miss_cnt++;
                $display("FAIL burst t=%0d {txd,done,empty,act}: got %b want %b", t, got_v, exp_v);
            end
            if (t == 0) if_a.wr_data = 8'h03;
            if (t == 1) if_a.wr_en = 1'b0;
            tick();
        end
        vec_cnt++;
        if (peak != 2) begin
            miss_cnt++;
            $display("FAIL burst_peak_count: got %0d want 2", peak);
        end
    endtask

    task automatic test_overflow();
        rx_q.delete();
        rx_err = 0;
        rx_en  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if_a.wr_data = 8'(i + 1);
            if_a.wr_en   = 1'b1;
            tick();
            vec_cnt++;
            if (if_a.overflow !== ((i == 5) ? 1'b1 : 1'b0) || if_a.full !== ((i >= 4) ? 1'b1 : 1'b0)) begin
                miss_cnt++;
                $display("FAIL overflow_write%0d: ovf=%b full=%b want %b %b", i, if_a.overflow, if_a.full,
                         (i == 5) ? 1'b1 : 1'b0, (i >= 4) ? 1'b1 : 1'b0);
            end
        end
        if_a.wr_en = 1'b0;
        tick();
        vec_cnt++;
        if (if_a.overflow !== 1'b0 || if_a.full !== 1'b1) begin
            miss_cnt++;
            $display("FAIL overflow_pulse_end: ovf=%b full=%b want 0 1", if_a.overflow, if_a.full);
        end
        for (int c = 0; c < 400 && rx_q.size() < 5; c++) tick();
        repeat (60) tick();
        vec_cnt++;
        if (rx_q.size() != 5 || rx_err != 0) begin
            miss_cnt++;
            $display("FAIL overflow_rx_count: got %0d bytes (%0d framing errs) want 5", rx_q.size(), rx_err);
        end
        for (int k = 0; k < 5 && k < rx_q.size(); k++) begin
            vec_cnt++;
            if (rx_q[k] !== 8'(k + 1)) begin
                miss_cnt++;
                $display("FAIL overflow_rx_byte%0d: got %h want %h", k, rx_q[k], 8'(k + 1));
            end
        end
        rx_en = 1'b0;
    endtask

    task automatic test_parity_stop2();
        logic [11:0] exp_e;
        logic [11:0] exp_o;
        exp_e = 12'b111000001110;  // 07, even parity bit 1, two stop bits
        exp_o = 12'b110000001110;  // 07, odd parity bit 0, two stop bits
        if_b.wr_data = 8'h07;
        if_c.wr_data = 8'h07;
        if_b.wr_en   = 1'b1;
        if_c.wr_en   = 1'b1;
        tick();
        if_b.wr_en = 1'b0;
        if_c.wr_en = 1'b0;
        tick();
        for (int t = 0; t < 48; t++) begin
            vec_cnt++;
            if (txd_b !== exp_e[t/4] || done_b !== 1'b0) begin
                miss_cnt++;
                $display("FAIL even_par t=%0d: txd=%b done=%b want %b 0", t, txd_b, done_b, exp_e[t/4]);
            end
            vec_cnt++;
            if (txd_c !== exp_o[t/4] || done_c !== 1'b0) begin
                miss_cnt++;
                $display("FAIL odd_par t=%0d: txd=%b done=%b want %b 0", t, txd_c, done_c, exp_o[t/4]);
            end
            tick();
        end
        vec_cnt++;
        if ({done_b, act_b, done_c, act_c} !== 4'b1010) begin
            miss_cnt++;
            $display("FAIL parity_frame_len: {done_b,act_b,done_c,act_c}=%b want 1010", {done_b, act_b, done_c, act_c});
        end
        tick();
    endtask

    task automatic test_wrap();
        int idx;
        int ovf_seen;
        int cnt_max;
        idx      = 0;
        ovf_seen = 0;
        cnt_max  = 0;
        rx_q.delete();
        rx_err = 0;
        rx_en  = 1'b1;
        for (int c = 0; c < 1200 && rx_q.size() < 10; c++) begin
            if (idx < 10 && if_a.count < 3'd3) begin
                if_a.wr_data = 8'(8'h10 + idx);
                if_a.wr_en   = 1'b1;
                idx++;
            end else begin
                if_a.wr_en = 1'b0;
            end
            tick();
            if (if_a.overflow === 1'b1) ovf_seen++;
            if (int'(if_a.count) > cnt_max) cnt_max = int'(if_a.count);
        end
        if_a.wr_en = 1'b0;
        repeat (10) tick();
        vec_cnt++;
        if (rx_q.size() != 10 || rx_err != 0) begin
            miss_cnt++;
            $display("FAIL wrap_rx_count: got %0d bytes (%0d framing errs) want 10", rx_q.size(), rx_err);
        end
        for (int k = 0; k < 10 && k < rx_q.size(); k++) begin
            vec_cnt++;
            if (rx_q[k] !== 8'(8'h10 + k)) begin
                miss_cnt++;
                $display("FAIL wrap_rx_byte%0d: got %h want %h", k, rx_q[k], 8'(8'h10 + k));
            end
        end
        vec_cnt++;
        if (ovf_seen != 0 || cnt_max > 3) begin
            miss_cnt++;
            $display("FAIL wrap_no_overflow: ovf pulses=%0d max count=%0d want 0 and <=3", ovf_seen, cnt_max);
        end
        rx_en = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int bad;
        bad = 0;
        if_a.wr_data = 8'h5A;
        if_a.wr_en   = 1'b1;
        tick();
        if_a.wr_data = 8'h33;
        tick();                  // first start bit on the line, t=0
        if_a.wr_data = 8'hC3;
        tick();                  // t=1
        if_a.wr_en = 1'b0;
        vec_cnt++;
        if (if_a.count !== 3'd2) begin
            miss_cnt++;
            $display("FAIL rstmid_queued: count=%0d want 2", if_a.count);
        end
        repeat (16) tick();      // t=17, inside data bit 3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vec_cnt++;
        if ({txd_a, act_a, if_a.count, if_a.empty, done_a} !== 7'b1_0_000_1_0) begin
            miss_cnt++;
            $display("FAIL rstmid_state: {txd,act,count,empty,done}=%b want 1000010", {txd_a, act_a, if_a.count, if_a.empty, done_a});
        end
        for (int c = 0; c < 100; c++) begin
            tick();
            if (done_a !== 1'b0 || txd_a !== 1'b1 || act_a !== 1'b0) bad++;
        end
        vec_cnt++;
        if (bad != 0) begin
            miss_cnt++;
            $display("FAIL rstmid_quiet: %0d active cycles want 0", bad);
        end
        if_a.wr_data = 8'h81;
        if_a.wr_en   = 1'b1;
        tick();
        if_a.wr_en = 1'b0;
        tick();
        vec_cnt++;
        if (txd_a !== 1'b0 || act_a !== 1'b1) begin
            miss_cnt++;
            $display("FAIL rstmid_restart: txd=%b act=%b want 0 1", txd_a, act_a);
        end
        repeat (40) tick();
        vec_cnt++;
        if (done_a !== 1'b1) begin
            miss_cnt++;
            $display("FAIL rstmid_restart_done: done=%b want 1", done_a);
        end
        tick();
    endtask

    initial begin
        rst          = 1'b1;
        if_a.wr_en   = 1'b0;
        if_b.wr_en   = 1'b0;
        if_c.wr_en   = 1'b0;
        if_a.wr_data = 8'h00;
        if_b.wr_data = 8'h00;
        if_c.wr_data = 8'h00;
        #2;
        test_reset();
        test_basic_frame();
        test_burst();
        test_overflow();
        test_parity_stop2();
        test_wrap();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
